// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART receive path.
//   uart_state_e   - receive framer FSM states (3-bit encoding)
//   UART_DATA_BITS - data bits per character
//   UART_GUARD     - clk cycles to ignore baud edges after a start edge
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_GUARD     = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer plus one delay flop with edge detect.
//   clk, rst_n - system clock, async active-low reset
//   din        - asynchronous input
//   sync       - synchronized level (second flop)
//   edge_p     - 1-cycle pulse: rising edge when RISE=1, falling edge when RISE=0
// RST_VAL sets all three flops at reset so no spurious edge follows reset.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1,
  parameter bit   RISE    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic edge_p
);

  logic meta;
  logic dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      dly  <= RST_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      dly  <= sync;
    end
  end

  assign edge_p = RISE ? (sync & ~dly) : (~sync & dly);

endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 (parameterisable) UART receive framer, LSB first.
//   clk, rst_n - system clock, async active-low reset
//   clk_bps    - baud square wave, rising edge at bit centre
//   mosi       - raw serial line, idle high
//   fifo_full  - RX FIFO full, sampled only when the stop bit is decided
//   wr_en      - 1-cycle FIFO write strobe, wr_data valid with it
//   wr_data    - received character, held between strobes
//   frame_err  - 1-cycle pulse when the stop bit samples 0
//   overrun    - 1-cycle pulse when a good character is dropped (FIFO full)
//   busy       - high whenever the framer is not IDLE
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = UART_DATA_BITS,
  parameter int unsigned GUARD     = UART_GUARD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_bps,
  input  logic                 mosi,
  input  logic                 fifo_full,
  output logic                 wr_en,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
  localparam int unsigned GRD_W = $clog2(GUARD + 1);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_BITS - 1);
  localparam logic [GRD_W-1:0] GUARD_LOAD = GRD_W'(GUARD);

  logic rx_s;
  logic start_edge;
  logic bps_rise;
  logic bps_level_unused;

  uart_rx_sync #(.RST_VAL(1'b1), .RISE(1'b0)) u_sync_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (mosi),
    .sync   (rx_s),
    .edge_p (start_edge)
  );

  uart_rx_sync #(.RST_VAL(1'b0), .RISE(1'b1)) u_sync_bps (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (clk_bps),
    .sync   (bps_level_unused),
    .edge_p (bps_rise)
  );

  uart_state_e           state, state_nxt;
  logic [GRD_W-1:0]      guard_cnt, guard_nxt;
  logic [CNT_W-1:0]      bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0]  shreg, shreg_nxt;
  logic [DATA_BITS-1:0]  wr_data_nxt;
  logic                  wr_en_nxt, frame_err_nxt, overrun_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      guard_cnt <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      guard_cnt <= guard_nxt;
      bit_cnt   <= bit_nxt;
      shreg     <= shreg_nxt;
      wr_en     <= wr_en_nxt;
      wr_data   <= wr_data_nxt;
      frame_err <= frame_err_nxt;
      overrun   <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    guard_nxt     = guard_cnt;
    bit_nxt       = bit_cnt;
    shreg_nxt     = shreg;
    wr_data_nxt   = wr_data;
    wr_en_nxt     = 1'b0;
    frame_err_nxt = 1'b0;
    overrun_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nxt = START;
          guard_nxt = GUARD_LOAD;
        end
      end
      START: begin
        // Baud edges during the guard window belong to the generator's
        // re-alignment, not to the start-bit centre.
        if (guard_cnt != '0) begin
          guard_nxt = guard_cnt - GRD_W'(1);
        end else if (bps_rise) begin
          if (!rx_s) begin
            state_nxt = DATA;
            bit_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (bps_rise) begin
          shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
          bit_nxt   = bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bps_rise) begin
          if (rx_s) begin
            state_nxt = IDLE;
            if (fifo_full) begin
              overrun_nxt = 1'b1;
            end else begin
              wr_en_nxt   = 1'b1;
              wr_data_nxt = shreg;
            end
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed, table-driven bench for uart_rx_byte.
// Bit period is shortened to 64 clk so the run stays small; clk_bps rises
// at each bit centre, with a short stray pulse early in every start bit
// that the guard window must swallow.
module tb_uart_rx_byte;

  localparam int BIT  = 64;
  localparam int HALF = BIT / 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_bps;
  logic       mosi;
  logic       fifo_full;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_byte #(.DATA_BITS(8), .GUARD(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_bps   (clk_bps),
    .mosi      (mosi),
    .fifo_full (fifo_full),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_bad = 0;

  int n_wr, n_fe, n_ov;
  int n_excl = 0;
  int n_wdchg = 0;
  int wr_cyc;
  int fall_cyc;
  logic [7:0] prev_wd = 8'h00;
  logic [7:0] wr_q[$];

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wr_en) begin
        n_wr++;
        wr_cyc = cyc;
        wr_q.push_back(wr_data);
      end
      if (frame_err) n_fe++;
      if (overrun) n_ov++;
      if ((int'(wr_en) + int'(frame_err) + int'(overrun)) > 1) n_excl++;
      if (wr_data !== prev_wd && !wr_en) n_wdchg++;
    end
    prev_wd = wr_data;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    n_wr = 0;
    n_fe = 0;
    n_ov = 0;
    wr_cyc = -1;
    wr_q.delete();
  endtask

  task automatic drive_bit(input logic v, input bit spur);
    mosi    = v;
    clk_bps = 1'b0;
    if (spur) begin
      clks(5);
      clk_bps = 1'b1;
      clks(4);
      clk_bps = 1'b0;
      clks(HALF - 9);
    end else begin
      clks(HALF);
    end
    clk_bps = 1'b1;
    clks(HALF);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    fall_cyc = cyc;
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 1'b0);
    drive_bit(stop, 1'b0);
  endtask

  task automatic toggle_bps(input int n);
    repeat (n) begin
      clk_bps = 1'b0;
      clks(HALF);
      clk_bps = 1'b1;
      clks(HALF);
    end
    clk_bps = 1'b0;
  endtask

  task automatic idle_bits(input int n);
    mosi = 1'b1;
    toggle_bps(n);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       full;
    int         exp_wr;
    int         exp_fe;
    int         exp_ov;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vt[6];
  logic [7:0] c3;
  int lat;

  initial begin
    // data,  stop, full, wr, fe, ov, wr_data afterwards
    vt[0] = '{8'hA5, 1'b1, 1'b0, 1, 0, 0, 8'hA5};
    vt[1] = '{8'h55, 1'b1, 1'b1, 0, 0, 1, 8'hA5};
    vt[2] = '{8'hC3, 1'b1, 1'b0, 1, 0, 0, 8'hC3};
    vt[3] = '{8'h00, 1'b0, 1'b0, 0, 1, 0, 8'hC3};
    vt[4] = '{8'hFF, 1'b0, 1'b1, 0, 1, 0, 8'hC3};
    vt[5] = '{8'h80, 1'b1, 1'b0, 1, 0, 0, 8'h80};

    rst_n     = 1'b0;
    mosi      = 1'b1;
    clk_bps   = 1'b0;
    fifo_full = 1'b0;
    clr();
    clks(3);
    check("reset_pulses", {29'd0, wr_en, frame_err, overrun}, 32'd0);
    check("reset_data", {24'd0, wr_data}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle_bits(2);

    for (int i = 0; i < 6; i++) begin
      clr();
      fifo_full = vt[i].full;
      send_frame(vt[i].data, vt[i].stop);
      idle_bits(2);
      fifo_full = 1'b0;
      check($sformatf("v%0d_wr", i), n_wr, vt[i].exp_wr);
      check($sformatf("v%0d_fe", i), n_fe, vt[i].exp_fe);
      check($sformatf("v%0d_ov", i), n_ov, vt[i].exp_ov);
      check($sformatf("v%0d_data", i), {24'd0, wr_data}, {24'd0, vt[i].exp_data});
      check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
      if (vt[i].exp_wr == 1) begin
        // stop centre at 9.5 bits, +2 synchronizer flops, +1 registered strobe
        lat = wr_cyc - fall_cyc;
        check($sformatf("v%0d_latency", i), lat, 9 * BIT + HALF + 3);
      end
    end

    // Short low glitch: start edge taken, start bit re-sampled high.
    clr();
    mosi    = 1'b0;
    clk_bps = 1'b0;
    clks(10);
    check("glitch_busy_early", {31'd0, busy}, 32'd1);
    clks(10);
    mosi = 1'b1;
    clks(10);
    check("glitch_busy_post_guard", {31'd0, busy}, 32'd1);
    clks(2);
    clk_bps = 1'b1;
    clks(8);
    check("glitch_busy_drop", {31'd0, busy}, 32'd0);
    idle_bits(1);
    check("glitch_no_pulse", n_wr + n_fe + n_ov, 0);

    // Framing error then line held low: must wait for the line to return high.
    clr();
    send_frame(8'h3C, 1'b0);
    toggle_bps(3);
    check("ferr_count", n_fe, 1);
    check("ferr_no_wr", n_wr + n_ov, 0);
    check("ferr_wait_idle_busy", {31'd0, busy}, 32'd1);
    mosi = 1'b1;
    clks(8);
    check("ferr_release_busy", {31'd0, busy}, 32'd0);
    idle_bits(1);
    clr();
    send_frame(8'h81, 1'b1);
    idle_bits(2);
    check("after_ferr_wr", n_wr, 1);
    check("after_ferr_data", {24'd0, wr_data}, 32'h81);

    // Back-to-back characters with a single stop bit each.
    clr();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h7E, 1'b1);
    idle_bits(2);
    check("b2b_count", n_wr, 3);
    check("b2b_0", {24'd0, (wr_q.size() > 0) ? wr_q[0] : 8'hxx}, 32'h00);
    check("b2b_1", {24'd0, (wr_q.size() > 1) ? wr_q[1] : 8'hxx}, 32'hFF);
    check("b2b_2", {24'd0, (wr_q.size() > 2) ? wr_q[2] : 8'hxx}, 32'h7E);
    check("b2b_fe_ov", n_fe + n_ov, 0);

    // Reset during bit 4 of 0xC3.
    clr();
    c3 = 8'hC3;
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive_bit(c3[i], 1'b0);
    mosi    = c3[4];
    clk_bps = 1'b0;
    clks(20);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    mosi  = 1'b1;
    #1;
    check("rst_async_pulses", {28'd0, wr_en, frame_err, overrun, busy}, 32'd0);
    check("rst_async_data", {24'd0, wr_data}, 32'd0);
    clks(10);
    rst_n = 1'b1;
    idle_bits(3);
    check("rst_no_pulse", n_wr + n_fe + n_ov, 0);
    check("rst_idle_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h5A, 1'b1);
    idle_bits(2);
    check("rst_next_wr", n_wr, 1);
    check("rst_next_data", {24'd0, wr_data}, 32'h5A);

    check("pulse_exclusive", n_excl, 0);
    check("wr_data_stable", n_wdchg, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
